// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
// Listens on an HD44780-style LCD bus and keeps a 2 x 16 character shadow of
// what the controller would display.
//
// Ports
//   CLK, RST_N        single clock, asynchronous active-low reset
//   LCD_RS            register select (0 = command, 1 = data)
//   LCD_RW            read/write (1 = read; read strobes are ignored)
//   LCD_E             enable strobe (falling edge latches the bus)
//   SF_D[11:8]        4-bit data bus
//   rd_addr[4:0]      buffer read index (0-15 line 1, 16-31 line 2)
//   rd_char[7:0]      character at rd_addr, one cycle later
//   cur_addr[6:0]     current DDRAM address
//   byte_valid        one-cycle pulse when a byte completes
//   byte_out[7:0]     the completed byte
//   byte_rs           RS value of the completed byte
//   mode_4bit         high once 4-bit mode has been entered
//   busy              high while a clear is sweeping the buffer
//   err               sticky; set when a strobe arrives during a clear
module lcd_bus_receiver (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LCD_RS,
    input  logic        LCD_RW,
    input  logic        LCD_E,
    input  logic [11:8] SF_D,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_char,
    output logic [6:0]  cur_addr,
    output logic        byte_valid,
    output logic [7:0]  byte_out,
    output logic        byte_rs,
    output logic        mode_4bit,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_INIT8 = 2'd0,
        S_HI    = 2'd1,
        S_LO    = 2'd2,
        S_CLR   = 2'd3
    } state_t;

    // Bus bundle layout inside the synchronizer: {E, RS, RW, D[3:0]}
    logic [6:0] sync1_r;
    logic [6:0] sync2_r;
    logic       e_prev_r;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] hi_r;
    logic [3:0] hi_nxt_s;
    logic [6:0] cur_r;
    logic [6:0] cur_nxt_s;
    logic       bv_r;
    logic       bv_nxt_s;
    logic [7:0] bo_r;
    logic [7:0] bo_nxt_s;
    logic       brs_r;
    logic       brs_nxt_s;
    logic       mode_r;
    logic       mode_nxt_s;
    logic       busy_r;
    logic       busy_nxt_s;
    logic       err_r;
    logic       err_nxt_s;
    logic [4:0] clr_cnt_r;
    logic [4:0] clr_cnt_nxt_s;

    logic       wr_en_s;
    logic [4:0] wr_idx_s;
    logic [7:0] wr_data_s;

    logic [7:0] buf_r [32];
    logic [7:0] rd_char_r;

    logic       strobe_s;
    logic       rs_s;
    logic       rw_s;
    logic [3:0] d_s;
    logic [7:0] byte_s;

    // DDRAM addresses that have a visible cell in the 16-column window
    function automatic logic addr_visible(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    // Line 2 (0x40-0x4F) lands at indices 16-31
    function automatic logic [4:0] addr_map(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // Each line is 40 cells long (0x00-0x27, 0x40-0x67); the end of one
    // line continues at the start of the other
    function automatic logic [6:0] addr_next(input logic [6:0] a);
        logic [6:0] n;
        if (a == 7'h27) begin
            n = 7'h40;
        end else if (a == 7'h67) begin
            n = 7'h00;
        end else begin
            n = a + 7'd1;
        end
        return n;
    endfunction

    // A strobe is the cycle in which synchronized E is seen having fallen
    assign strobe_s = e_prev_r & ~sync2_r[6];
    assign rs_s     = sync2_r[5];
    assign rw_s     = sync2_r[4];
    assign d_s      = sync2_r[3:0];
    assign byte_s   = {hi_r, d_s};

    // Two-flop synchronizer for the whole bus plus the edge-detect delay
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_r  <= 7'd0;
            sync2_r  <= 7'd0;
            e_prev_r <= 1'b0;
        end else begin
            sync1_r  <= {LCD_E, LCD_RS, LCD_RW, SF_D};
            sync2_r  <= sync1_r;
            e_prev_r <= sync2_r[6];
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= S_INIT8;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, byte assembly, command decode and buffer write port
    always_comb begin
        state_nxt_s   = state_r;
        hi_nxt_s      = hi_r;
        cur_nxt_s     = cur_r;
        bv_nxt_s      = 1'b0;
        bo_nxt_s      = bo_r;
        brs_nxt_s     = brs_r;
        mode_nxt_s    = mode_r;
        busy_nxt_s    = busy_r;
        err_nxt_s     = err_r;
        clr_cnt_nxt_s = clr_cnt_r;
        wr_en_s       = 1'b0;
        wr_idx_s      = 5'd0;
        wr_data_s     = 8'h20;
        case (state_r)
            S_INIT8: begin
                // 8-bit-mode function-set writes: reported, never executed
                if (strobe_s && !rw_s && !rs_s) begin
                    bv_nxt_s  = 1'b1;
                    bo_nxt_s  = {d_s, 4'h0};
                    brs_nxt_s = 1'b0;
                    if (d_s == 4'h2) begin
                        state_nxt_s = S_HI;
                        mode_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = S_INIT8;
                    end
                end else begin
                    state_nxt_s = S_INIT8;
                end
            end
            S_HI: begin
                if (strobe_s && !rw_s) begin
                    hi_nxt_s    = d_s;
                    state_nxt_s = S_LO;
                end else begin
                    state_nxt_s = S_HI;
                end
            end
            S_LO: begin
                if (strobe_s && !rw_s) begin
                    bv_nxt_s    = 1'b1;
                    bo_nxt_s    = byte_s;
                    brs_nxt_s   = rs_s;
                    state_nxt_s = S_HI;
                    if (rs_s) begin
                        if (addr_visible(cur_r)) begin
                            wr_en_s   = 1'b1;
                            wr_idx_s  = addr_map(cur_r);
                            wr_data_s = byte_s;
                        end else begin
                            wr_en_s   = 1'b0;
                        end
                        cur_nxt_s = addr_next(cur_r);
                    end else begin
                        case (byte_s)
                            8'h01: begin
                                cur_nxt_s     = 7'd0;
                                state_nxt_s   = S_CLR;
                                busy_nxt_s    = 1'b1;
                                clr_cnt_nxt_s = 5'd0;
                            end
                            8'h02, 8'h03: begin
                                cur_nxt_s = 7'd0;
                            end
                            default: begin
                                if (byte_s[7]) begin
                                    cur_nxt_s = byte_s[6:0];
                                end else begin
                                    cur_nxt_s = cur_r;
                                end
                            end
                        endcase
                    end
                end else begin
                    state_nxt_s = S_LO;
                end
            end
            S_CLR: begin
                wr_en_s       = 1'b1;
                wr_idx_s      = clr_cnt_r;
                wr_data_s     = 8'h20;
                clr_cnt_nxt_s = clr_cnt_r + 5'd1;
                if (clr_cnt_r == 5'd31) begin
                    state_nxt_s = S_HI;
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = S_CLR;
                end
                // Writes arriving mid-clear are lost; the nibble phase stays put
                if (strobe_s && !rw_s) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
            end
            default: begin
                state_nxt_s = S_INIT8;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hi_r      <= 4'h0;
            cur_r     <= 7'd0;
            bv_r      <= 1'b0;
            bo_r      <= 8'h00;
            brs_r     <= 1'b0;
            mode_r    <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            clr_cnt_r <= 5'd0;
        end else begin
            hi_r      <= hi_nxt_s;
            cur_r     <= cur_nxt_s;
            bv_r      <= bv_nxt_s;
            bo_r      <= bo_nxt_s;
            brs_r     <= brs_nxt_s;
            mode_r    <= mode_nxt_s;
            busy_r    <= busy_nxt_s;
            err_r     <= err_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Character buffer; a same-cycle read of the written entry sees the old value
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) begin
                buf_r[i] <= 8'h20;
            end
            rd_char_r <= 8'h20;
        end else begin
            if (wr_en_s) begin
                buf_r[wr_idx_s] <= wr_data_s;
            end
            rd_char_r <= buf_r[rd_addr];
        end
    end

    assign rd_char    = rd_char_r;
    assign cur_addr   = cur_r;
    assign byte_valid = bv_r;
    assign byte_out   = bo_r;
    assign byte_rs    = brs_r;
    assign mode_4bit  = mode_r;
    assign busy       = busy_r;
    assign err        = err_r;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver
// Drives nibble strobes onto the LCD bus and compares the receiver against a
// byte/character-level model of the display controller.
module tb_lcd_bus_receiver;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LCD_RS = 1'b0;
    logic       LCD_RW = 1'b0;
    logic       LCD_E = 1'b0;
    logic [3:0] SF_D = 4'h0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic [6:0] cur_addr;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_rs;
    logic       mode_4bit;
    logic       busy;
    logic       err;

    lcd_bus_receiver dut (
        .CLK(CLK), .RST_N(RST_N), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_E(LCD_E), .SF_D(SF_D), .rd_addr(rd_addr), .rd_char(rd_char),
        .cur_addr(cur_addr), .byte_valid(byte_valid), .byte_out(byte_out),
        .byte_rs(byte_rs), .mode_4bit(mode_4bit), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    // Reference model: display contents and controller status
    logic [7:0] m_buf [32];
    int         m_cur;
    int         m_phase;      // 0 = awaiting init, 1 = high nibble next, 2 = low nibble next
    logic [3:0] m_hi;
    logic       m_mode;
    logic       m_err;
    logic       m_clr;
    logic [8:0] exp_q [$];
    logic [8:0] obs_q [$];
    int         busy_cycles = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte monitor and busy-cycle counter
    always @(posedge CLK) begin
        if (RST_N && byte_valid) obs_q.push_back({byte_rs, byte_out});
        if (RST_N && busy) busy_cycles++;
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_cur = 0; m_phase = 0; m_hi = 4'h0;
        m_mode = 1'b0; m_err = 1'b0; m_clr = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic model_exec(input logic rs, input logic [7:0] b);
        if (rs) begin
            if (m_cur < 16) m_buf[m_cur] = b;
            else if (m_cur >= 64 && m_cur < 80) m_buf[16 + m_cur - 64] = b;
            if (m_cur == 39) m_cur = 64;
            else if (m_cur == 103) m_cur = 0;
            else m_cur = (m_cur + 1) % 128;
        end else if (b == 8'h01) begin
            for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
            m_cur = 0;
            m_clr = 1'b1;
        end else if (b == 8'h02 || b == 8'h03) begin
            m_cur = 0;
        end else if (b >= 8'h80) begin
            m_cur = int'(b) - 128;
        end
    endtask

    task automatic model_strobe(input logic rs, input logic rw, input logic [3:0] d);
        if (rw) begin
            // reads never touch state
        end else if (m_clr) begin
            m_err = 1'b1;
        end else if (m_phase == 0) begin
            if (!rs) begin
                exp_q.push_back({1'b0, d, 4'h0});
                if (d == 4'h2) begin
                    m_phase = 1;
                    m_mode = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            m_hi = d;
            m_phase = 2;
        end else begin
            exp_q.push_back({rs, m_hi, d});
            m_phase = 1;
            model_exec(rs, {m_hi, d});
        end
    endtask

    task automatic send_nibble(input logic rs, input logic rw, input logic [3:0] d);
        @(negedge CLK);
        LCD_RS = rs; LCD_RW = rw; SF_D = d; LCD_E = 1'b1;
        repeat (4) @(negedge CLK);
        LCD_E = 1'b0;
        repeat (6) @(negedge CLK);
        model_strobe(rs, rw, d);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input logic rw_noise);
        send_nibble(rs, 1'b0, b[7:4]);
        if (rw_noise) send_nibble($urandom_range(0, 1), 1'b1, 4'($urandom_range(0, 15)));
        send_nibble(rs, 1'b0, b[3:0]);
    endtask

    task automatic wait_clear_done();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_value("clear_timeout", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        m_clr = 1'b0;
    endtask

    task automatic compare_bytes(input string tag);
        check_value({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check_value({tag, "_byte"}, obs_q.pop_front(), exp_q.pop_front());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        compare_bytes(tag);
        check_value({tag, "_cur"}, cur_addr, m_cur);
        check_value({tag, "_mode"}, mode_4bit, m_mode);
        check_value({tag, "_err"}, err, m_err);
        check_value({tag, "_busy"}, busy, 1'b0);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            @(negedge CLK);
            check_value($sformatf("%s_buf%0d", tag, i), rd_char, m_buf[i]);
        end
    endtask

    task automatic do_init();
        send_nibble(1'b0, 1'b0, 4'h3);
        send_nibble(1'b0, 1'b0, 4'h3);
        send_nibble(1'b0, 1'b0, 4'h3);
        send_nibble(1'b0, 1'b0, 4'h2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] pre31;
        int start;
        int sel;
        model_reset();
        repeat (3) @(negedge CLK);
        // reset values while held
        check_value("rst_rd_char", rd_char, 8'h20);
        check_value("rst_cur", cur_addr, 7'd0);
        check_value("rst_bv", byte_valid, 1'b0);
        check_value("rst_bo", byte_out, 8'h00);
        check_value("rst_mode", mode_4bit, 1'b0);
        check_value("rst_busy", busy, 1'b0);
        check_value("rst_err", err, 1'b0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // data before init is ignored
        send_byte(1'b1, 8'h41, 1'b0);
        do_init();
        check_state("init");

        send_byte(1'b0, 8'h80, 1'b0);
        send_byte(1'b1, 8'h54, 1'b0);
        send_byte(1'b1, 8'h69, 1'b0);
        check_state("write");

        send_byte(1'b0, 8'hC0, 1'b0);
        send_byte(1'b1, 8'h50, 1'b1);
        send_byte(1'b0, 8'hA7, 1'b0);
        send_byte(1'b1, 8'h41, 1'b1);
        check_state("wrap");

        // randomized traffic
        for (int op = 0; op < 48; op++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) b = 8'($urandom_range(0, 255));
            else if (sel < 7) b = 8'h80 | 8'($urandom_range(0, 127));
            else if (sel < 8) b = 8'($urandom_range(2, 3));
            else b = 8'($urandom_range(4, 127));
            send_byte(sel < 5, b, $urandom_range(0, 3) == 0);
            if (op % 12 == 11) check_state($sformatf("rnd%0d", op));
        end

        // clear with a strobe dropped mid-sweep
        send_byte(1'b0, 8'hCF, 1'b0);
        send_byte(1'b1, 8'h7E, 1'b0);
        pre31 = m_buf[31];
        start = busy_cycles;
        send_byte(1'b0, 8'h01, 1'b0);
        send_nibble(1'b1, 1'b0, 4'h5);
        rd_addr = 5'd31;
        @(negedge CLK);
        check_value("clr_read_old", rd_char, pre31);
        wait_clear_done();
        check_value("clr_busy_len", busy_cycles - start, 32'd32);
        check_state("clear");
        send_byte(1'b1, 8'h33, 1'b0);
        check_state("post_clear");

        // reset while waiting for the low nibble
        send_nibble(1'b1, 1'b0, 4'h6);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check_value("mid_rst_rd_char", rd_char, 8'h20);
        check_value("mid_rst_cur", cur_addr, 7'd0);
        check_value("mid_rst_bo", byte_out, 8'h00);
        check_value("mid_rst_brs", byte_rs, 1'b0);
        check_value("mid_rst_mode", mode_4bit, 1'b0);
        check_value("mid_rst_err", err, 1'b0);
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        send_nibble(1'b1, 1'b0, 4'h4);
        send_nibble(1'b1, 1'b0, 4'h8);
        check_state("after_rst");
        do_init();
        send_byte(1'b1, 8'h5A, 1'b0);
        check_state("reinit");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_receiver.md
LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 SHALL have no parameters; the buffer is fixed at 2 lines x 16 characters.
REQ-002 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port LCD_RS, input, 1: register select (0 = command, 1 = data).
REQ-005 SHALL have port LCD_RW, input, 1: read/write (1 = read).
REQ-006 SHALL have port LCD_E, input, 1: enable strobe.
REQ-007 SHALL have port SF_D, input, [11:8]: 4-bit data bus.
REQ-008 SHALL have port rd_addr, input, 5: buffer read index (0-15 = line 1, 16-31 = line 2).
REQ-009 SHALL have port rd_char, output, 8: character stored at rd_addr.
REQ-010 SHALL have port cur_addr, output, 7: current DDRAM address.
REQ-011 SHALL have port byte_valid, output, 1: one-cycle pulse when a byte completes.
REQ-012 SHALL have port byte_out, output, 8: the completed byte.
REQ-013 SHALL have port byte_rs, output, 1: RS value of the completed byte.
REQ-014 SHALL have port mode_4bit, output, 1: high once 4-bit mode is entered.
REQ-015 SHALL have port busy, output, 1: high while a clear is in progress.
REQ-016 SHALL have port err, output, 1: sticky flag set when a strobe is dropped.

Function
REQ-017 SHALL pass LCD_E, LCD_RS, LCD_RW and SF_D through a 2-flop synchronizer.
REQ-018 SHALL define a strobe as a falling edge of synchronized E, detected one cycle after the second flop; RS, RW and D are sampled in that same cycle.
REQ-019 SHALL ignore strobes with RW = 1: no state, nibble-phase or address change.
REQ-020 SHALL use states S_INIT8, S_HI, S_LO and S_CLR.
REQ-021 S_INIT8: each RS = 0 strobe SHALL form the byte {D, 4'h0}, pulse byte_valid and not be executed. D = 4'h2 SHALL move the block to S_HI and set mode_4bit.
REQ-022 S_INIT8: RS = 1 strobes SHALL be ignored.
REQ-023 S_HI: a strobe SHALL latch D as the high nibble and move to S_LO.
REQ-024 S_LO: a strobe SHALL complete the byte {hi, D} and move to S_HI. byte_valid SHALL pulse the next cycle with byte_out and byte_rs.
REQ-025 RS = 1 byte: buf[map(cur_addr)] SHALL be written if cur_addr is in 0x00-0x0F or 0x40-0x4F; otherwise no write. cur_addr SHALL then increment.
REQ-026 Address increment SHALL wrap 0x27 -> 0x40 and 0x67 -> 0x00.
REQ-027 map(a) SHALL be a[3:0] for line 1 and 16 + a[3:0] for line 2.
REQ-028 Command 0x01 SHALL set cur_addr = 0, enter S_CLR and assert busy.
REQ-029 S_CLR SHALL write 0x20 to one entry per cycle for 32 cycles, then return to S_HI and deassert busy.
REQ-030 Command 0x02 or 0x03 SHALL set cur_addr = 0.
REQ-031 Command with bit7 = 1 SHALL set cur_addr = byte[6:0].
REQ-032 All other commands SHALL be accepted without effect (byte_valid still pulses).
REQ-033 A strobe arriving in S_CLR SHALL be dropped, set err and not advance the nibble phase.
REQ-034 rd_char SHALL be registered with 1-cycle latency from rd_addr; reads SHALL be allowed during S_CLR and return the current content.
REQ-035 A write and a read of the same entry in the same cycle SHALL return the old value.

Reset
REQ-036 RST_N low SHALL asynchronously set: state S_INIT8, all 32 entries 0x20, cur_addr 0, rd_char 0x20, byte_out 0, byte_rs 0, byte_valid 0, mode_4bit 0, busy 0, err 0, synchronizer flops 0, hi nibble 0.
REQ-037 Reset asserted mid-byte or mid-clear SHALL abort the operation; after release the block SHALL wait for a new 0x3,0x3,0x3,0x2 init sequence.

Verification
REQ-038 Init: nibble strobes 3,3,3,2 (RS = 0) -> four byte_valid pulses with 0x30,0x30,0x30,0x20; mode_4bit = 1 after the fourth.
REQ-039 Write: cmd 0x80, data 0x54 0x69 -> rd_addr 0 = 0x54, rd_addr 1 = 0x69, cur_addr = 0x02.
REQ-040 Line 2 and wrap: cmd 0xC0, data 0x50 -> rd_addr 16 = 0x50. cmd 0xA7, data 0x41 -> no buffer change, cur_addr = 0x40.
REQ-041 Clear: fill entries, cmd 0x01 -> busy high for exactly 32 cycles, all entries 0x20, cur_addr 0. A strobe sent mid-clear -> err = 1.
REQ-042 RW = 1 strobes interleaved between a high and low nibble -> ignored; byte assembles correctly.
REQ-043 Reset while in S_LO -> all outputs at reset values; a subsequent data strobe without init -> no buffer change.
